// File: rtl/l2_bus_interface.sv
// l2_bus_interface: queues L2 line requests (READ/RFO/WRITEBACK/INVALIDATE) in
// a FIFO and runs each as one FSB transaction: arbitrate, address, snoop
// window, data, then a single-cycle response back to L2.
// Optional feature: define BIU_TIMEOUT_EN to enable the ARB/DATA watchdog that
// aborts a stalled transaction with rsp_err=1.
module l2_bus_interface #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 512,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SNOOP_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_op,
  output logic [LINE_W-1:0] rsp_data,
  output logic [1:0]        rsp_snoop,
  output logic              rsp_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_addr_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [1:0]        snoop_result,
  input  logic [LINE_W-1:0] bus_data_in,
  input  logic              bus_data_valid,
  output logic [LINE_W-1:0] bus_data_out,
  output logic              bus_data_oe
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SC_W  = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {OP_READ, OP_RFO, OP_WB, OP_INV} op_t;
  typedef enum logic [2:0] {IDLE, ARB, ADDR, SNOOP, DATA, RESP} state_t;

  state_t state, state_nx;

  logic [1:0]        fifo_op   [DEPTH];
  logic [ADDR_W-7:0] fifo_addr [DEPTH];
  logic [LINE_W-1:0] fifo_data [DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              empty, full, push, pop;

  logic [1:0]        lat_op;
  logic [ADDR_W-7:0] lat_addr;
  logic [LINE_W-1:0] lat_data;
  logic [LINE_W-1:0] data_q;
  logic [1:0]        snoop_q;
  logic              err_q;
  logic [SC_W-1:0]   scnt;
  logic              arb_wait, data_wait, timeout_hit;
  logic              unused_bits;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign arb_wait  = (state == ARB) && !bus_gnt;
  assign data_wait = (state == DATA) && !lat_op[1] && !bus_data_valid;

`ifdef BIU_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt;

  // Watchdog: cleared while idle, counts stalled ARB/DATA cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                     tcnt <= '0;
    else if (state == IDLE)         tcnt <= '0;
    else if (arb_wait || data_wait) tcnt <= tcnt + TW'(1);
  end

  assign timeout_hit = (arb_wait || data_wait) && (tcnt == TW'(TIMEOUT - 1));
  assign unused_bits = ^req_addr[5:0];
`else
  assign timeout_hit = 1'b0;
  assign unused_bits = ^{req_addr[5:0], (TIMEOUT != 0)};
`endif

  // FIFO storage; line offset bits are dropped at the write port.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr[PTR_W-1:0]]   <= req_op;
      fifo_addr[wr_ptr[PTR_W-1:0]] <= req_addr[ADDR_W-1:6];
      fifo_data[wr_ptr[PTR_W-1:0]] <= req_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FIFO pointers, latched request, snoop counter and response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lat_op   <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      data_q   <= '0;
      snoop_q  <= '0;
      err_q    <= 1'b0;
      scnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        lat_op   <= fifo_op[rd_ptr[PTR_W-1:0]];
        lat_addr <= fifo_addr[rd_ptr[PTR_W-1:0]];
        lat_data <= fifo_data[rd_ptr[PTR_W-1:0]];
        data_q   <= '0;
        snoop_q  <= '0;
        err_q    <= 1'b0;
      end
      if (state == ADDR)
        scnt <= SC_W'(SNOOP_CYCLES - 1);
      else if (state == SNOOP && scnt != '0)
        scnt <= scnt - SC_W'(1);
      if (state == SNOOP && scnt == '0 && lat_op != OP_WB)
        snoop_q <= snoop_result;
      if (state == DATA && !lat_op[1] && bus_data_valid)
        data_q <= bus_data_in;
      if (timeout_hit) begin
        err_q   <= 1'b1;
        snoop_q <= '0;
        data_q  <= '0;
      end
    end
  end

  // Next-state and Moore outputs; every output defaults to 0.
  always_comb begin
    state_nx       = state;
    bus_req        = 1'b0;
    bus_addr_valid = 1'b0;
    bus_op         = '0;
    bus_addr       = '0;
    bus_data_out   = '0;
    bus_data_oe    = 1'b0;
    rsp_valid      = 1'b0;
    rsp_op         = '0;
    rsp_data       = '0;
    rsp_snoop      = '0;
    rsp_err        = 1'b0;
    case (state)
      IDLE: if (!empty) state_nx = ARB;
      ARB: begin
        bus_req = 1'b1;
        if (bus_gnt)          state_nx = ADDR;
        else if (timeout_hit) state_nx = RESP;
      end
      ADDR: begin
        bus_req        = 1'b1;
        bus_addr_valid = 1'b1;
        bus_op         = lat_op;
        bus_addr       = {lat_addr, 6'b0};
        state_nx       = SNOOP;
      end
      SNOOP: begin
        bus_req = 1'b1;
        if (scnt == '0) state_nx = (lat_op == OP_INV) ? RESP : DATA;
      end
      DATA: begin
        bus_req = 1'b1;
        if (lat_op == OP_WB) begin
          bus_data_oe  = 1'b1;
          bus_data_out = lat_data;
          state_nx     = RESP;
        end else if (bus_data_valid || timeout_hit) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_op    = lat_op;
        rsp_data  = data_q;
        rsp_snoop = snoop_q;
        rsp_err   = err_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_bus_interface.sv
// Testbench for l2_bus_interface: directed vector table, hand-written
// corner-case sequences and randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_l2_bus_interface;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned LINE_W       = 512;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned SNOOP_CYCLES = 2;

  typedef logic [LINE_W-1:0] line_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_data = '0;
  logic              rsp_valid;
  logic [1:0]        rsp_op;
  logic [LINE_W-1:0] rsp_data;
  logic [1:0]        rsp_snoop;
  logic              rsp_err;
  logic              bus_req;
  logic              bus_gnt = 1'b0;
  logic              bus_addr_valid;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        snoop_result = '0;
  logic [LINE_W-1:0] bus_data_in = '0;
  logic              bus_data_valid = 1'b0;
  logic [LINE_W-1:0] bus_data_out;
  logic              bus_data_oe;

  always #5 clk = ~clk;

  l2_bus_interface #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH),
    .SNOOP_CYCLES(SNOOP_CYCLES), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .rsp_snoop(rsp_snoop), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr_valid(bus_addr_valid),
    .bus_op(bus_op), .bus_addr(bus_addr), .snoop_result(snoop_result),
    .bus_data_in(bus_data_in), .bus_data_valid(bus_data_valid),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe)
  );

  // One request plus the bus behaviour to apply and the expected timing.
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    line_t       wdata;
    logic [1:0]  snoop;
    int          gw;            // ARB cycles with gnt=0
    int          dw;            // DATA cycles before data_valid (READ/RFO)
    int          exp_lat;       // accept edge -> rsp_valid cycle
    int          exp_addr_cyc;  // accept edge -> bus_addr_valid cycle
    bit          exp_err;
  } vec_t;

  typedef struct {
    vec_t v;
    int   accept_cyc;
    bit   exact;
  } txn_t;

  txn_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    gnt_hold = 1'b0;
  vec_t  vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic line_t rand_line();
    line_t r;
    r = '0;
    for (int i = 0; i < int'(LINE_W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Bus agent and response model: plays the FSB side and checks every
  // response against the oldest outstanding request.
  int    phase = 0;
  int    sn = 0;
  int    ac = 0;
  int    dwc = 0;
  line_t exp_fill = '0;
  initial begin
    forever begin
      txn_t t;
      line_t ed;
      logic [1:0] es;
      @(negedge clk);
      #1;
      bus_gnt        = 1'b0;
      bus_data_valid = 1'b0;
      bus_data_in    = rand_line();
      snoop_result   = 2'($urandom);
      if (!rst_n) begin
        phase = 0;
        ac    = 0;
      end else begin
        if (!(phase == 2 && q.size() > 0 && q[0].v.op == 2'b10)) begin
          chk("idle data_oe", line_t'({bus_data_oe, bus_data_out != '0}), line_t'(0));
        end
        if (!rsp_valid) begin
          chk("idle rsp fields", line_t'({rsp_op, rsp_snoop, rsp_err, rsp_data != '0}), line_t'(0));
        end
        if (rsp_valid) begin
          chk("bus_req in resp", line_t'(bus_req), line_t'(0));
          if (q.size() == 0) fail("unexpected rsp");
          else begin
            t  = q.pop_front();
            ed = (t.v.exp_err || t.v.op[1]) ? '0 : exp_fill;
            es = (t.v.exp_err || t.v.op == 2'b10) ? 2'b00 : t.v.snoop;
            chk("rsp_op", line_t'(rsp_op), line_t'(t.v.op));
            chk("rsp_data", rsp_data, ed);
            chk("rsp_snoop", line_t'(rsp_snoop), line_t'(es));
            chk("rsp_err", line_t'(rsp_err), line_t'(t.v.exp_err));
            if (t.exact)
              chk("rsp latency", line_t'(cyc - t.accept_cyc + 1), line_t'(t.v.exp_lat));
          end
          phase = 0;
          ac    = 0;
        end else if (phase == 0) begin
          if (bus_addr_valid) begin
            if (q.size() == 0) fail("unexpected addr phase");
            else begin
              chk("bus_op", line_t'(bus_op), line_t'(q[0].v.op));
              chk("bus_addr", line_t'(bus_addr), line_t'(q[0].v.addr & 32'hFFFF_FFC0));
              chk("bus_req in addr", line_t'(bus_req), line_t'(1));
              if (q[0].exact)
                chk("addr latency", line_t'(cyc - q[0].accept_cyc + 1), line_t'(q[0].v.exp_addr_cyc));
            end
            phase = 1;
            sn    = 1;
          end else if (bus_req) begin
            bus_gnt = !gnt_hold && q.size() > 0 && ac >= q[0].v.gw;
            ac++;
          end
        end else if (phase == 1) begin
          chk("bus_req in snoop", line_t'(bus_req), line_t'(1));
          if (sn == int'(SNOOP_CYCLES)) begin
            if (q.size() > 0) snoop_result = q[0].v.snoop;
            phase = 2;
            dwc   = 0;
          end
          sn++;
        end else if (phase == 2 && q.size() > 0) begin
          chk("bus_req in data", line_t'(bus_req), line_t'(1));
          if (q[0].v.op == 2'b10) begin
            chk("wb data_oe", line_t'(bus_data_oe), line_t'(1));
            chk("wb data_out", bus_data_out, q[0].v.wdata);
            phase = 3;
          end else if (q[0].v.op == 2'b11) begin
            fail("invalidate entered data phase");
            phase = 3;
          end else begin
            bus_data_valid = (dwc == q[0].v.dw);
            if (bus_data_valid) begin
              exp_fill = bus_data_in;
              phase    = 3;
            end
            dwc++;
          end
        end
      end
    end
  end

  // Drive one request at the current negedge once ready, hold for one edge.
  task automatic push(input vec_t v, input bit exact);
    int budget = 300;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!req_ready) begin
      fail("push ready timeout");
      return;
    end
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    req_data  = v.wdata;
    q.push_back('{v: v, accept_cyc: cyc + 1, exact: exact});
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = rand_line();
  endtask

  task automatic drain(input int budget);
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      fail("drain timeout");
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   budget;
    vecs[0] = '{2'b00, 32'h0000_1000, '0,                   2'b00, 0, 0, 7,  3, 1'b0};
    vecs[1] = '{2'b10, 32'h0000_2040, {16{32'hA5A5_A5A5}},  2'b01, 0, 0, 7,  3, 1'b0};
    vecs[2] = '{2'b11, 32'h0000_3000, '0,                   2'b01, 0, 0, 6,  3, 1'b0};
    vecs[3] = '{2'b01, 32'h0000_4000, '0,                   2'b10, 0, 3, 10, 3, 1'b0};
    vecs[4] = '{2'b00, 32'h0000_5023, '0,                   2'b01, 2, 1, 10, 5, 1'b0};
    vecs[5] = '{2'b10, 32'h0000_6000, {16{32'h5A5A_5A5A}},  2'b10, 1, 0, 8,  4, 1'b0};
    vecs[6] = '{2'b11, 32'h0000_7FC0, '0,                   2'b10, 3, 0, 9,  6, 1'b0};
    vecs[7] = '{2'b01, 32'hFFFF_FFFF, '0,                   2'b00, 0, 0, 7,  3, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset req_ready", line_t'(req_ready), line_t'(1));
    chk("reset bus outputs", line_t'({bus_req, bus_addr_valid, bus_op, bus_addr != '0, bus_data_oe}), line_t'(0));
    chk("reset rsp outputs", line_t'({rsp_valid, rsp_op, rsp_snoop, rsp_err, rsp_data != '0}), line_t'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      push(vecs[i], 1'b1);
      drain(100);
    end

    // Grant held off: the FIFO fills behind the transaction stuck in ARB.
    gnt_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = '{2'(i % 4), 32'h0001_0000 + 32'(i * 64), rand_line(), 2'(i % 3), 0, i % 2, 0, 0, 1'b0};
      push(v, 1'b0);
    end
    chk("ready low when full", line_t'(req_ready), line_t'(0));
    gnt_hold = 1'b0;
    drain(300);

    // Reset during the snoop window: no response, bus released.
    v = '{2'b00, 32'h0002_0000, '0, 2'b01, 0, 0, 0, 0, 1'b0};
    push(v, 1'b0);
    budget = 20;
    while (phase != 1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (phase != 1) fail("snoop phase not reached");
    chk("bus_req before reset", line_t'(bus_req), line_t'(1));
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("reset abort bus_req", line_t'(bus_req), line_t'(0));
    chk("reset abort req_ready", line_t'(req_ready), line_t'(1));
    chk("reset abort rsp_valid", line_t'(rsp_valid), line_t'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no rsp after reset", line_t'({rsp_valid, bus_req}), line_t'(0));
    end

    // Randomized traffic; model is the in-order request queue.
    for (int i = 0; i < 40; i++) begin
      v.op           = 2'($urandom_range(0, 3));
      v.addr         = $urandom;
      v.wdata        = rand_line();
      v.snoop        = 2'($urandom_range(0, 2));
      v.gw           = int'($urandom_range(0, 3));
      v.dw           = int'($urandom_range(0, 3));
      v.exp_lat      = 0;
      v.exp_addr_cyc = 0;
      v.exp_err      = 1'b0;
      push(v, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(2000);

`ifdef BIU_TIMEOUT_EN
    gnt_hold = 1'b1;
    v = '{2'b00, 32'h0003_0000, '0, 2'b01, 0, 0, 66, 0, 1'b1};
    push(v, 1'b1);
    drain(100);
    gnt_hold = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
